// File: rtl/sram_rw_arbiter.sv
// -----------------------------------------------------------------------------
// sram_rw_arbiter
//
// Front-end controller for one single-port SRAM macro (1-cycle read latency,
// segment-masked writes). A write requester and a read requester share the
// macro's RW port under round-robin arbitration. Read responses are held under
// back-pressure by idling the macro, so its registered output stays put and no
// data buffer is needed.
//
// Optional feature macro: SRAM_RW_ARBITER_INIT_EN
//   defined   : after reset the controller zero-fills every entry (DEPTH
//               cycles, one entry per cycle) before accepting requests.
//   undefined : no sweep; requests are accepted from the first cycle after
//               reset and the SRAM contents are whatever the macro holds.
//
// Ports
//   clock, reset           : sole clock (also the macro clock), sync active-high
//   init_done              : high once the controller accepts requests
//   w_valid/w_ready        : write handshake; w_addr, w_mask, w_data payload
//   r_valid/r_ready        : read handshake; r_addr payload
//   resp_valid/resp_ready  : read response handshake; resp_data = sram_rdata
//   sram_addr/en/wmode/wmask/wdata : macro command (wmode 1 = write)
//   sram_rdata             : macro read data
// -----------------------------------------------------------------------------
module sram_rw_arbiter #(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 1316,
   parameter int MASK_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   output logic              init_done,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [MASK_W-1:0] w_mask,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [ADDR_W-1:0] r_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_en,
   output logic              sram_wmode,
   output logic [MASK_W-1:0] sram_wmask,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   if ((ADDR_W != $clog2(DEPTH)) || ((DATA_W % MASK_W) != 0)) begin : g_bad_params
      $error("sram_rw_arbiter: ADDR_W must be clog2(DEPTH) and MASK_W must divide DATA_W");
   end

   logic resp_valid_q, resp_valid_d;
   // 1 when the most recent grant went to the write side; reset value 0 makes
   // the first contended cycle go to the write side.
   logic last_w_q, last_w_d;
   logic stall;

`ifdef SRAM_RW_ARBITER_INIT_EN
   typedef enum logic {S_INIT, S_RUN} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         resp_valid_q <= 1'b0;
         last_w_q     <= 1'b0;
`ifdef SRAM_RW_ARBITER_INIT_EN
         state_q      <= S_INIT;
         cnt_q        <= '0;
`endif
      end else begin
         resp_valid_q <= resp_valid_d;
         last_w_q     <= last_w_d;
`ifdef SRAM_RW_ARBITER_INIT_EN
         state_q      <= state_d;
         cnt_q        <= cnt_d;
`endif
      end
   end

   // A pending response the consumer is not taking freezes the macro.
   assign stall      = resp_valid_q && !resp_ready;
   assign resp_valid = resp_valid_q;
   assign resp_data  = sram_rdata;

   always_comb begin
      init_done    = 1'b0;
      w_ready      = 1'b0;
      r_ready      = 1'b0;
      sram_en      = 1'b0;
      sram_wmode   = 1'b0;
      sram_addr    = '0;
      sram_wmask   = '0;
      sram_wdata   = '0;
      resp_valid_d = resp_valid_q;
      last_w_d     = last_w_q;
`ifdef SRAM_RW_ARBITER_INIT_EN
      state_d      = state_q;
      cnt_d        = cnt_q;
`endif

      // While reset is asserted every control output is held at its idle
      // value, so the macro sees no command even though the state register
      // only changes at the clock edge.
      if (!reset) begin
`ifdef SRAM_RW_ARBITER_INIT_EN
         if (state_q == S_INIT) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_wmask = '1;
            sram_addr  = cnt_q;
            cnt_d      = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = S_RUN;
            end
         end else
`endif
         begin
            init_done = 1'b1;
            if (!stall) begin
               // Contention goes to the side that did not win last time.
               if (w_valid && (!r_valid || !last_w_q)) begin
                  w_ready = 1'b1;
               end else if (r_valid) begin
                  r_ready = 1'b1;
               end
            end

            if (w_ready) begin
               sram_en    = 1'b1;
               sram_wmode = 1'b1;
               sram_addr  = w_addr;
               sram_wmask = w_mask;
               sram_wdata = w_data;
            end else if (r_ready) begin
               sram_en   = 1'b1;
               sram_addr = r_addr;
            end
         end
      end

      // A new read keeps the response slot full even if the old one is
      // consumed this cycle, which sustains one read per cycle.
      if (r_ready) begin
         resp_valid_d = 1'b1;
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end

      if (w_ready || r_ready) begin
         last_w_d = w_ready;
      end
   end

endmodule
